// File: rtl/occ_req_arbiter_if.sv
// Channel and Occ-memory signal bundle for the Occ request arbiter.
// slave = arbiter view, master = channel/memory environment view.
interface occ_req_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_req_valid;
    logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
    logic [NUM_CH-1:0]        ch_req_ready;
    logic [NUM_CH-1:0]        ch_rsp_valid;
    logic [DATA_W-1:0]        ch_rsp_data;
    logic                     ce_rom_Occ_o;
    logic [ADDR_W-1:0]        addr_rom_Occ_o;
    logic [DATA_W-1:0]        data_Occ_i;
    logic                     data_valid;
    logic                     busy_o;
    logic                     err_o;

    modport slave (
        input  ch_req_valid, ch_req_addr, data_Occ_i, data_valid,
        output ch_req_ready, ch_rsp_valid, ch_rsp_data,
               ce_rom_Occ_o, addr_rom_Occ_o, busy_o, err_o
    );

    modport master (
        output ch_req_valid, ch_req_addr, data_Occ_i, data_valid,
        input  ch_req_ready, ch_rsp_valid, ch_rsp_data,
               ce_rom_Occ_o, addr_rom_Occ_o, busy_o, err_o
    );
endinterface

// File: rtl/occ_req_arbiter.sv
// Round-robin arbiter sharing one Occ memory port among NUM_CH search engines.
// In-order responses are steered back to their issuer through a tag FIFO.
module occ_req_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    occ_req_arbiter_if.slave   io_bus
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int RW = $clog2(NUM_CH);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW-1:0] C_MAX  = CW'(MAX_OUT);
    localparam logic [CW-1:0] C_LAST = CW'(MAX_OUT - 1);
    localparam logic [RW-1:0] R_LAST = RW'(NUM_CH - 1);
    localparam logic [RW:0]   R_NUM  = (RW + 1)'(NUM_CH);

    logic [RW-1:0]     r_rr_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_rd_ptr;
    logic [RW-1:0]     r_tag_mem [MAX_OUT];
    logic              r_ce;
    logic [ADDR_W-1:0] r_addr;
    logic [NUM_CH-1:0] r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_err;

    logic [ADDR_W-1:0] w_req_addr [NUM_CH];
    logic [NUM_CH-1:0] w_ready;
    logic [NUM_CH-1:0] w_head_onehot;
    logic [RW:0]       w_scan;
    logic [RW-1:0]     w_grant_idx;
    logic [RW-1:0]     w_head_tag;
    logic              w_found;
    logic              w_push;
    logic              w_pop;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_req_addr[gi]    = io_bus.ch_req_addr[gi*ADDR_W +: ADDR_W];
            assign w_ready[gi]       = w_push && (w_grant_idx == RW'(gi));
            assign w_head_onehot[gi] = (w_head_tag == RW'(gi));
        end
    endgenerate

    // First valid channel at or after r_rr_ptr, wrapping at NUM_CH-1.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (RW + 1)'(k);
            if (w_scan >= R_NUM) begin
                w_scan = w_scan - R_NUM;
            end
            if (!w_found && io_bus.ch_req_valid[w_scan[RW-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan[RW-1:0];
            end
        end
    end

    // Slot availability looks only at the registered count: a pop in the same cycle does not free it.
    assign w_push     = w_found && (r_count < C_MAX);
    assign w_pop      = io_bus.data_valid && (r_count != '0);
    assign w_head_tag = r_tag_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr[PW-1:0]] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ce        <= 1'b0;
            r_addr      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_ce        <= w_push;
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            if (w_push) begin
                r_addr   <= w_req_addr[w_grant_idx];
                r_rr_ptr <= (w_grant_idx == R_LAST) ? '0 : w_grant_idx + 1'b1;
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rsp_data <= io_bus.data_Occ_i;
                r_rd_ptr   <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (io_bus.data_valid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_bus.ch_req_ready   = w_ready;
    assign io_bus.ch_rsp_valid   = r_rsp_valid;
    assign io_bus.ch_rsp_data    = r_rsp_data;
    assign io_bus.ce_rom_Occ_o   = r_ce;
    assign io_bus.addr_rom_Occ_o = r_addr;
    assign io_bus.busy_o         = (r_count != '0) || r_ce;
    assign io_bus.err_o          = r_err;
endmodule

// File: tb/tb_occ_req_arbiter.sv
// Directed bench for occ_req_arbiter: per-cycle vector table plus hand-written
// sequences for FIFO full/stall, pointer wrap, stray returns and mid-flight reset.
module tb_occ_req_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    occ_req_arbiter_if #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32)) bus ();

    occ_req_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .MAX_OUT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] data;
        logic [3:0]  e_ready;
        logic        e_ce;
        logic [7:0]  e_addr;
        logic [3:0]  e_rsp;
        logic [31:0] e_rdata;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic [3:0] v, logic [31:0] a, logic dv, logic [31:0] d,
                                logic [3:0] er, logic ec, logic [7:0] ea, logic [3:0] ers,
                                logic [31:0] erd, logic eb, logic ee);
        vec_t t;
        t.valid = v;  t.addr = a;  t.dv = dv;  t.data = d;
        t.e_ready = er;  t.e_ce = ec;  t.e_addr = ea;  t.e_rsp = ers;
        t.e_rdata = erd;  t.e_busy = eb;  t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic [3:0] v, input logic [31:0] a, input logic dv, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.ch_req_valid = v;
        bus.ch_req_addr  = a;
        bus.data_valid   = dv;
        bus.data_Occ_i   = d;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(bus.ch_req_ready), 32'h0);
        chk({tag, "_ce"},    32'(bus.ce_rom_Occ_o), 32'h0);
        chk({tag, "_addr"},  32'(bus.addr_rom_Occ_o), 32'h0);
        chk({tag, "_rsp"},   32'(bus.ch_rsp_valid), 32'h0);
        chk({tag, "_rdata"}, bus.ch_rsp_data, 32'h0);
        chk({tag, "_busy"},  32'(bus.busy_o), 32'h0);
        chk({tag, "_err"},   32'(bus.err_o), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        bus.ch_req_valid = '0;
        bus.ch_req_addr  = '0;
        bus.data_valid   = 1'b0;
        bus.data_Occ_i   = '0;
        rst = 1'b1;
        @(negedge clk);
        chk_idle(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0]  s3_ready [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    logic        s3_dv    [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  s3_rsp   [9] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.ch_req_valid = '0;
        bus.ch_req_addr  = '0;
        bus.data_valid   = 1'b0;
        bus.data_Occ_i   = '0;
        #1 rst = 1'b1;

        // Rows 0-9: all channels, L=1. Rows 10-18: ch1/ch3 only, L=2, addr wiggles before grant.
        tbl[0]  = mk(4'hF, 32'h2322_2120, 0, 32'h0,         4'h1, 0, 8'h00, 4'h0, 32'h0,         0, 0);
        tbl[1]  = mk(4'hF, 32'h2322_2120, 0, 32'h0,         4'h2, 1, 8'h20, 4'h0, 32'h0,         1, 0);
        tbl[2]  = mk(4'hF, 32'h2322_2120, 1, 32'hD000_0000, 4'h4, 1, 8'h21, 4'h0, 32'h0,         1, 0);
        tbl[3]  = mk(4'hF, 32'h2322_2120, 1, 32'hD000_0001, 4'h8, 1, 8'h22, 4'h1, 32'hD000_0000, 1, 0);
        tbl[4]  = mk(4'hF, 32'h2322_2120, 1, 32'hD000_0002, 4'h1, 1, 8'h23, 4'h2, 32'hD000_0001, 1, 0);
        tbl[5]  = mk(4'hF, 32'h2322_2120, 1, 32'hD000_0003, 4'h2, 1, 8'h20, 4'h4, 32'hD000_0002, 1, 0);
        tbl[6]  = mk(4'hF, 32'h2322_2120, 1, 32'hD000_0004, 4'h4, 1, 8'h21, 4'h8, 32'hD000_0003, 1, 0);
        tbl[7]  = mk(4'h0, 32'h2322_2120, 1, 32'hD000_0005, 4'h0, 1, 8'h22, 4'h1, 32'hD000_0004, 1, 0);
        tbl[8]  = mk(4'h0, 32'h2322_2120, 1, 32'hD000_0006, 4'h0, 0, 8'h22, 4'h2, 32'hD000_0005, 1, 0);
        tbl[9]  = mk(4'h0, 32'h2322_2120, 0, 32'h0,         4'h0, 0, 8'h22, 4'h4, 32'hD000_0006, 0, 0);
        tbl[10] = mk(4'hA, 32'hA500_7700, 0, 32'h0,         4'h8, 0, 8'h22, 4'h0, 32'hD000_0006, 0, 0);
        tbl[11] = mk(4'hA, 32'h5500_1000, 0, 32'h0,         4'h2, 1, 8'hA5, 4'h0, 32'hD000_0006, 1, 0);
        tbl[12] = mk(4'hA, 32'hA500_1000, 0, 32'h0,         4'h8, 1, 8'h10, 4'h0, 32'hD000_0006, 1, 0);
        tbl[13] = mk(4'hA, 32'hA500_1000, 1, 32'hE000_0000, 4'h2, 1, 8'hA5, 4'h0, 32'hD000_0006, 1, 0);
        tbl[14] = mk(4'h0, 32'hA500_1000, 1, 32'hE000_0001, 4'h0, 1, 8'h10, 4'h8, 32'hE000_0000, 1, 0);
        tbl[15] = mk(4'h0, 32'hA500_1000, 1, 32'hE000_0002, 4'h0, 0, 8'h10, 4'h2, 32'hE000_0001, 1, 0);
        tbl[16] = mk(4'h0, 32'hA500_1000, 1, 32'hE000_0003, 4'h0, 0, 8'h10, 4'h8, 32'hE000_0002, 1, 0);
        tbl[17] = mk(4'h0, 32'hA500_1000, 0, 32'h0,         4'h0, 0, 8'h10, 4'h2, 32'hE000_0003, 0, 0);
        tbl[18] = mk(4'h0, 32'hA500_1000, 0, 32'h0,         4'h0, 0, 8'h10, 4'h0, 32'hE000_0003, 0, 0);

        do_reset("rst0");

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].valid, tbl[i].addr, tbl[i].dv, tbl[i].data);
            chk($sformatf("t%0d_ready", i), 32'(bus.ch_req_ready), 32'(tbl[i].e_ready));
            chk($sformatf("t%0d_ce", i),    32'(bus.ce_rom_Occ_o), 32'(tbl[i].e_ce));
            chk($sformatf("t%0d_addr", i),  32'(bus.addr_rom_Occ_o), 32'(tbl[i].e_addr));
            chk($sformatf("t%0d_rsp", i),   32'(bus.ch_rsp_valid), 32'(tbl[i].e_rsp));
            chk($sformatf("t%0d_rdata", i), bus.ch_rsp_data, tbl[i].e_rdata);
            chk($sformatf("t%0d_busy", i),  32'(bus.busy_o), 32'(tbl[i].e_busy));
            chk($sformatf("t%0d_err", i),   32'(bus.err_o), 32'(tbl[i].e_err));
            $display("vec %0d ready=%h ce=%b addr=%h rsp=%h data=%h busy=%b err=%b", i,
                     bus.ch_req_ready, bus.ce_rom_Occ_o, bus.addr_rom_Occ_o,
                     bus.ch_rsp_valid, bus.ch_rsp_data, bus.busy_o, bus.err_o);
        end

        // Stray return with nothing outstanding: sticky error, no response, normal traffic continues.
        step(4'h0, 32'h0, 1'b1, 32'h0000_BAD0);
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s4_err",   32'(bus.err_o), 32'h1);
        chk("s4_rsp",   32'(bus.ch_rsp_valid), 32'h0);
        chk("s4_rdata", bus.ch_rsp_data, 32'hE000_0003);
        step(4'h1, 32'h0000_005A, 1'b0, 32'h0);
        chk("s4_ready", 32'(bus.ch_req_ready), 32'h1);
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s4_ce",    32'(bus.ce_rom_Occ_o), 32'h1);
        chk("s4_addr",  32'(bus.addr_rom_Occ_o), 32'h5A);
        step(4'h0, 32'h0, 1'b1, 32'h0000_C4C4);
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s4_rsp2",  32'(bus.ch_rsp_valid), 32'h1);
        chk("s4_data2", bus.ch_rsp_data, 32'h0000_C4C4);
        chk("s4_stick", 32'(bus.err_o), 32'h1);
        $display("seq4 stray return done");

        // Memory stall with ch2 always requesting: four grants, then blocked until one pop.
        do_reset("rst2");
        chk("s2_err_cleared", 32'(bus.err_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(4'h4, 32'h0040_0000, 1'b0, 32'h0);
            chk($sformatf("s2_fill%0d", i), 32'(bus.ch_req_ready), 32'h4);
        end
        for (int i = 0; i < 2; i++) begin
            step(4'h4, 32'h0040_0000, 1'b0, 32'h0);
            chk($sformatf("s2_full%0d", i), 32'(bus.ch_req_ready), 32'h0);
        end
        step(4'h4, 32'h0040_0000, 1'b1, 32'h2222_0000);
        chk("s2_nobypass", 32'(bus.ch_req_ready), 32'h0);
        step(4'h4, 32'h0040_0000, 1'b0, 32'h0);
        chk("s2_after_pop", 32'(bus.ch_req_ready), 32'h4);
        chk("s2_rsp",       32'(bus.ch_rsp_valid), 32'h4);
        chk("s2_rdata",     bus.ch_rsp_data, 32'h2222_0000);
        step(4'h4, 32'h0040_0000, 1'b0, 32'h0);
        chk("s2_full_again", 32'(bus.ch_req_ready), 32'h0);
        chk("s2_ce_addr",    32'(bus.addr_rom_Occ_o), 32'h40);
        for (int j = 0; j < 5; j++) begin
            step(4'h0, 32'h0, (j < 4), 32'h2222_0001 + 32'(j));
            if (j > 0) begin
                chk($sformatf("s2_drain_rsp%0d", j), 32'(bus.ch_rsp_valid), 32'h4);
                chk($sformatf("s2_drain_dat%0d", j), bus.ch_rsp_data, 32'h2222_0000 + 32'(j));
            end
        end
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s2_idle_busy", 32'(bus.busy_o), 32'h0);
        $display("seq2 stall done");

        // Push+pop at count 2 across the pointer wrap; count checked by fill-to-full afterwards.
        do_reset("rst3");
        for (int i = 0; i < 9; i++) begin
            step(4'hF, 32'h3332_3130, s3_dv[i], 32'hF000_0000 + 32'(i - 2));
            chk($sformatf("s3_ready%0d", i), 32'(bus.ch_req_ready), 32'(s3_ready[i]));
            chk($sformatf("s3_rsp%0d", i),   32'(bus.ch_rsp_valid), 32'(s3_rsp[i]));
            if (s3_rsp[i] != 4'h0) begin
                chk($sformatf("s3_dat%0d", i), bus.ch_rsp_data, 32'hF000_0000 + 32'(i - 3));
            end
        end
        for (int j = 0; j < 5; j++) begin
            step(4'h0, 32'h3332_3130, (j < 4), 32'hF000_0004 + 32'(j));
            if (j > 0) begin
                chk($sformatf("s3_drain_rsp%0d", j), 32'(bus.ch_rsp_valid), 32'(4'h1 << (j - 1)));
                chk($sformatf("s3_drain_dat%0d", j), bus.ch_rsp_data, 32'hF000_0003 + 32'(j));
            end
        end
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s3_idle_busy", 32'(bus.busy_o), 32'h0);
        chk("s3_idle_rsp",  32'(bus.ch_rsp_valid), 32'h0);
        $display("seq3 wrap done");

        // Asynchronous reset with three requests in flight.
        do_reset("rst5");
        step(4'hF, 32'h5352_5150, 1'b0, 32'h0);
        step(4'hF, 32'h5352_5150, 1'b0, 32'h0);
        step(4'hF, 32'h5352_5150, 1'b0, 32'h0);
        chk("s5_pre_ce",   32'(bus.ce_rom_Occ_o), 32'h1);
        chk("s5_pre_addr", 32'(bus.addr_rom_Occ_o), 32'h51);
        @(posedge clk);
        #1;
        bus.ch_req_valid = '0;
        rst = 1'b1;
        #1;
        chk_idle("s5_async");
        @(negedge clk);
        rst = 1'b0;
        step(4'h0, 32'h0, 1'b1, 32'h5555_0000);
        step(4'h0, 32'h0, 1'b0, 32'h0);
        chk("s5_err",  32'(bus.err_o), 32'h1);
        chk("s5_rsp",  32'(bus.ch_rsp_valid), 32'h0);
        chk("s5_busy", 32'(bus.busy_o), 32'h0);
        $display("seq5 reset in flight done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
